pixel_word_packer: RTL

PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

---
 rtl/pixel_word_packer_pkg.sv | 16 +
 rtl/pixel_word_packer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pixel_word_packer_pkg.sv
// Shared types and constants for the RGB-to-32-bit word packer.
// Four 24-bit pixels fill exactly three 32-bit words.
package pixel_word_packer_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam int          PHASE_W   = 2;
   localparam int          BYTE_W    = 8;
   localparam int          PIX_W     = 3 * BYTE_W;
   localparam int          WORD_W    = 4 * BYTE_W;
   localparam logic [3:0]  TKEEP_ALL = 4'hF;

endpackage

// File: rtl/pixel_word_packer.sv
// Packs {r,g,b} pixels little-endian into 32-bit stream words.
// Lines are closed on eol, and any partial word is padded and sent by a FLUSH cycle.
module pixel_word_packer
   import pixel_word_packer_pkg::*;
#(
   parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic [7:0]         r,
   input  logic [7:0]         g,
   input  logic [7:0]         b,
   input  logic               valid,
   input  logic               sof,
   input  logic               eol,
   output logic               in_stream_ready,
   output logic [WORD_W-1:0]  out_stream_tdata,
   output logic [3:0]         out_stream_tkeep,
   output logic               out_stream_tlast,
   output logic               out_stream_tuser,
   output logic               out_stream_tvalid,
   input  logic               out_stream_tready,
   output state_t             dbg_state_o,
   output logic [PHASE_W-1:0] dbg_phase_o,
   output logic               dbg_sof_misalign_o
);

   state_t               state_q, state_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [PIX_W-1:0]     res_q, res_d;
   logic                 sof_pend_q, sof_pend_d;
   logic                 mis_q, mis_d;
   logic [WORD_W-1:0]    tdata_q, tdata_d;
   logic                 tlast_q, tlast_d;
   logic                 tuser_q, tuser_d;
   logic                 tvalid_q, tvalid_d;

   logic [PIX_W-1:0]     pix;
   logic [PHASE_W-1:0]   eff_phase;
   logic                 accept;
   logic                 out_free;
   logic                 ld;
   logic [WORD_W-1:0]    ld_data;
   logic                 ld_last;
   logic                 ld_user;

   assign pix      = {r, g, b};
   assign out_free = ~tvalid_q | out_stream_tready;
   // Ready is forced low while reset is held, even though the state is RUN.
   assign in_stream_ready = aresetn & (state_q == ST_RUN) & out_free;
   assign accept   = valid & in_stream_ready;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      res_d      = res_q;
      sof_pend_d = sof_pend_q;
      mis_d      = mis_q;
      eff_phase  = phase_q;
      ld         = 1'b0;
      ld_data    = '0;
      ld_last    = 1'b0;
      ld_user    = 1'b0;

      if (state_q == ST_RUN) begin
         if (accept) begin
            // A sof pixel always restarts packing at lane 0, dropping any residue.
            eff_phase  = sof ? '0 : phase_q;
            sof_pend_d = 1'b0;
            if (sof && (phase_q != '0)) mis_d = 1'b1;
            unique case (eff_phase)
               2'd0: begin
                  if (eol) begin
                     ld      = 1'b1;
                     ld_data = {PAD_BYTE, pix};
                     ld_last = 1'b1;
                     ld_user = sof;
                     res_d   = '0;
                     phase_d = 2'd0;
                  end else begin
                     res_d      = pix;
                     phase_d    = 2'd1;
                     sof_pend_d = sof;
                  end
               end
               2'd1: begin
                  ld      = 1'b1;
                  ld_data = {pix[7:0], res_q};
                  ld_user = sof_pend_q;
                  res_d   = {8'h00, pix[23:8]};
                  phase_d = 2'd2;
                  if (eol) state_d = ST_FLUSH;
               end
               2'd2: begin
                  ld      = 1'b1;
                  ld_data = {pix[15:0], res_q[15:0]};
                  res_d   = {16'h0000, pix[23:16]};
                  phase_d = 2'd3;
                  if (eol) state_d = ST_FLUSH;
               end
               default: begin
                  ld      = 1'b1;
                  ld_data = {pix, res_q[7:0]};
                  ld_last = eol;
                  res_d   = '0;
                  phase_d = 2'd0;
               end
            endcase
         end
      end else if (out_free) begin
         // Phase tells how many residue bytes remain: 2 after a phase-1 eol, 1 after phase-2.
         ld      = 1'b1;
         ld_data = (phase_q == 2'd2) ? {PAD_BYTE, PAD_BYTE, res_q[15:0]}
                                     : {PAD_BYTE, PAD_BYTE, PAD_BYTE, res_q[7:0]};
         ld_last = 1'b1;
         res_d   = '0;
         phase_d = 2'd0;
         state_d = ST_RUN;
      end

      tvalid_d = ld | (tvalid_q & ~out_stream_tready);
      tdata_d  = ld ? ld_data : tdata_q;
      tlast_d  = ld ? ld_last : tlast_q;
      tuser_d  = ld ? ld_user : tuser_q;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_RUN;
         phase_q    <= '0;
         res_q      <= '0;
         sof_pend_q <= 1'b0;
         mis_q      <= 1'b0;
         tdata_q    <= '0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
         tvalid_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         res_q      <= res_d;
         sof_pend_q <= sof_pend_d;
         mis_q      <= mis_d;
         tdata_q    <= tdata_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
         tvalid_q   <= tvalid_d;
      end
   end

   assign out_stream_tdata   = tdata_q;
   assign out_stream_tkeep   = TKEEP_ALL;
   assign out_stream_tlast   = tlast_q;
   assign out_stream_tuser   = tuser_q;
   assign out_stream_tvalid  = tvalid_q;
   assign dbg_state_o        = state_q;
   assign dbg_phase_o        = phase_q;
   assign dbg_sof_misalign_o = mis_q;

endmodule
